// File: rtl/motor_pkg.sv
// Shared types and constants for the motor drive monitor (motor_mon, pwm_cap).
package motor_pkg;

    localparam int PWM_BITS   = 10;
    localparam int PWM_PERIOD = 1 << PWM_BITS;

    typedef logic [1:0] mode_t;

    localparam mode_t BRAKE = 2'b00;
    localparam mode_t FWD   = 2'b01;
    localparam mode_t REV   = 2'b10;
    localparam mode_t FAULT = 2'b11;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } mon_state_t;

endpackage

// File: rtl/pwm_cap.sv
// Per-side capture: counts fwd/rev high cycles over one window and converts
// the window totals into a signed command plus brake/fault flags.
module pwm_cap
    import motor_pkg::*;
#(
    parameter int PWM_BITS = motor_pkg::PWM_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              term,
    input  logic              fwd,
    input  logic              rev,
    output logic [PWM_BITS:0] meas,
    output logic              brk,
    output logic              flt
);

    logic [PWM_BITS:0]   f_cnt;
    logic [PWM_BITS:0]   r_cnt;
    logic [PWM_BITS:0]   f_tot;
    logic [PWM_BITS:0]   r_tot;
    logic [PWM_BITS-1:0] f_sat;
    logic [PWM_BITS-1:0] r_sat;
    mode_t               mode;

    // Totals include the current sample so the terminal cycle is counted.
    assign f_tot = f_cnt + {{PWM_BITS{1'b0}}, fwd};
    assign r_tot = r_cnt + {{PWM_BITS{1'b0}}, rev};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_cnt <= '0;
            r_cnt <= '0;
        end else if (clr || term) begin
            f_cnt <= '0;
            r_cnt <= '0;
        end else begin
            f_cnt <= f_tot;
            r_cnt <= r_tot;
        end
    end

    // A full-window count (MSB set) saturates to the largest magnitude.
    assign f_sat = f_tot[PWM_BITS] ? '1 : f_tot[PWM_BITS-1:0];
    assign r_sat = r_tot[PWM_BITS] ? '1 : r_tot[PWM_BITS-1:0];

    always_comb begin
        mode = BRAKE;
        if (f_tot != '0 && r_tot != '0) begin
            mode = (f_tot[PWM_BITS] && r_tot[PWM_BITS]) ? BRAKE : FAULT;
        end else if (f_tot != '0) begin
            mode = FWD;
        end else if (r_tot != '0) begin
            mode = REV;
        end
    end

    always_comb begin
        meas = '0;
        brk  = 1'b0;
        flt  = 1'b0;
        case (mode)
            FWD:     meas = {1'b0, f_sat};
            REV:     meas = '0 - {1'b0, r_sat};
            FAULT:   flt  = 1'b1;
            default: brk  = f_tot[PWM_BITS] && r_tot[PWM_BITS];
        endcase
    end

endmodule

// File: rtl/motor_mon.sv
// H-bridge drive monitor: recovers signed left/right commands per PWM window.
// Define MOTOR_MON_SYNC_EN to pass the drive pins through 2-flop synchronisers.
module motor_mon
    import motor_pkg::*;
#(
    parameter int PWM_BITS = motor_pkg::PWM_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              fwd_lft,
    input  logic              rev_lft,
    input  logic              fwd_rht,
    input  logic              rev_rht,
    output logic [PWM_BITS:0] lft_meas,
    output logic [PWM_BITS:0] rht_meas,
    output logic              lft_brk,
    output logic              rht_brk,
    output logic              lft_flt,
    output logic              rht_flt,
    output logic              meas_vld
);

    logic fl_s, rl_s, fr_s, rr_s;

`ifdef MOTOR_MON_SYNC_EN
    logic [3:0] sync_q1;
    logic [3:0] sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {fwd_lft, rev_lft, fwd_rht, rev_rht};
            sync_q2 <= sync_q1;
        end
    end

    assign {fl_s, rl_s, fr_s, rr_s} = sync_q2;
`else
    assign {fl_s, rl_s, fr_s, rr_s} = {fwd_lft, rev_lft, fwd_rht, rev_rht};
`endif

    logic [PWM_BITS-1:0] win_cnt;
    logic                term;
    mon_state_t          state;
    mon_state_t          state_nxt;
    logic                eval;

    assign term = &win_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       win_cnt <= '0;
        else if (restart) win_cnt <= '0;
        else              win_cnt <= win_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WARM;
        else        state <= state_nxt;
    end

    // restart has priority over the terminal cycle, so no evaluation then.
    always_comb begin
        state_nxt = state;
        eval      = 1'b0;
        if (restart) begin
            state_nxt = WARM;
        end else if (term) begin
            case (state)
                WARM:    state_nxt = RUN;
                default: eval      = 1'b1;
            endcase
        end
    end

    logic [PWM_BITS:0] lft_m, rht_m;
    logic              lft_b, rht_b, lft_f, rht_f;

    pwm_cap #(.PWM_BITS(PWM_BITS)) u_cap_lft (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart),
        .term  (term),
        .fwd   (fl_s),
        .rev   (rl_s),
        .meas  (lft_m),
        .brk   (lft_b),
        .flt   (lft_f)
    );

    pwm_cap #(.PWM_BITS(PWM_BITS)) u_cap_rht (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart),
        .term  (term),
        .fwd   (fr_s),
        .rev   (rr_s),
        .meas  (rht_m),
        .brk   (rht_b),
        .flt   (rht_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_meas <= '0;
            rht_meas <= '0;
            lft_brk  <= 1'b0;
            rht_brk  <= 1'b0;
            lft_flt  <= 1'b0;
            rht_flt  <= 1'b0;
            meas_vld <= 1'b0;
        end else begin
            meas_vld <= eval;
            if (eval) begin
                lft_meas <= lft_m;
                rht_meas <= rht_m;
                lft_brk  <= lft_b;
                rht_brk  <= rht_b;
                lft_flt  <= lft_f;
                rht_flt  <= rht_f;
            end
        end
    end

endmodule

// File: tb/tb_motor_mon.sv
// Directed bench for motor_mon: table of steady duty patterns plus hand-written
// sequences for reset cadence, blending, restart-on-terminal and async reset.
`timescale 1ns/1ps
module tb_motor_mon;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic        fwd_lft = 1'b0, rev_lft = 1'b0, fwd_rht = 1'b0, rev_rht = 1'b0;
    logic [10:0] lft_meas, rht_meas;
    logic        lft_brk, rht_brk, lft_flt, rht_flt, meas_vld;

    always #5 clk = ~clk;

    motor_mon dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .fwd_lft  (fwd_lft),
        .rev_lft  (rev_lft),
        .fwd_rht  (fwd_rht),
        .rev_rht  (rev_rht),
        .lft_meas (lft_meas),
        .rht_meas (rht_meas),
        .lft_brk  (lft_brk),
        .rht_brk  (rht_brk),
        .lft_flt  (lft_flt),
        .rht_flt  (rht_flt),
        .meas_vld (meas_vld)
    );

    // Reference PWM driver with a phase unrelated to the monitor window.
    int d_fl = 0, d_rl = 0, d_fr = 0, d_rr = 0;
    int pwm_cnt = 417;

    always @(posedge clk) begin
        #1;
        pwm_cnt = (pwm_cnt + 1) % 1024;
        fwd_lft = (pwm_cnt < d_fl);
        rev_lft = (pwm_cnt < d_rl);
        fwd_rht = (pwm_cnt < d_fr);
        rev_rht = (pwm_cnt < d_rr);
    end

    typedef struct {
        int          fl, rl, fr, rr;
        logic [10:0] lm;
        logic        lb, lf;
        logic [10:0] rm;
        logic        rb, rf;
    } vec_t;

    vec_t vecs[8];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_vld(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (meas_vld) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic set_duty(input vec_t v);
        d_fl = v.fl;
        d_rl = v.rl;
        d_fr = v.fr;
        d_rr = v.rr;
    endtask

    task automatic check_vec(input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        chk({tag, "_lft_meas"}, int'(lft_meas), int'(vecs[idx].lm));
        chk({tag, "_lft_brk"},  int'(lft_brk),  int'(vecs[idx].lb));
        chk({tag, "_lft_flt"},  int'(lft_flt),  int'(vecs[idx].lf));
        chk({tag, "_rht_meas"}, int'(rht_meas), int'(vecs[idx].rm));
        chk({tag, "_rht_brk"},  int'(rht_brk),  int'(vecs[idx].rb));
        chk({tag, "_rht_flt"},  int'(rht_flt),  int'(vecs[idx].rf));
    endtask

    initial begin
        int cyc;
        int held_errs;

        //          fl    rl    fr    rr    lm        lb    lf    rm        rb    rf
        vecs[0] = '{300,  0,    0,    1023, 11'h12C, 1'b0, 1'b0, 11'h401, 1'b0, 1'b0};
        vecs[1] = '{1024, 1024, 200,  50,   11'h000, 1'b1, 1'b0, 11'h000, 1'b0, 1'b1};
        vecs[2] = '{0,    0,    1024, 0,    11'h000, 1'b0, 1'b0, 11'h3FF, 1'b0, 1'b0};
        vecs[3] = '{0,    1,    1023, 1024, 11'h7FF, 1'b0, 1'b0, 11'h000, 1'b0, 1'b1};
        vecs[4] = '{1,    0,    0,    0,    11'h001, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0};
        vecs[5] = '{500,  0,    0,    1024, 11'h1F4, 1'b0, 1'b0, 11'h401, 1'b0, 1'b0};
        vecs[6] = '{1024, 1023, 512,  0,    11'h000, 1'b0, 1'b1, 11'h200, 1'b0, 1'b0};
        vecs[7] = '{0,    700,  1024, 1024, 11'h544, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0};

        // Reset state, then first pulse 2048 cycles after release.
        set_duty(vecs[0]);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_lft_meas", int'(lft_meas), 0);
        chk("rst_rht_meas", int'(rht_meas), 0);
        chk("rst_flags", int'({lft_brk, rht_brk, lft_flt, rht_flt}), 0);
        chk("rst_meas_vld", int'(meas_vld), 0);
        rst_n = 1'b1;
        wait_vld(3000, cyc);
        chk("first_vld_cycle", cyc, 2048);
        check_vec(0);
        @(negedge clk);
        chk("vld_width", int'(meas_vld), 0);
        wait_vld(2000, cyc);
        chk("vld_cadence", cyc, 1023);

        // Table: the window after a duty change may blend; the next is exact.
        for (int i = 1; i < 8; i++) begin
            set_duty(vecs[i]);
            wait_vld(1100, cyc);
            chk($sformatf("vec%0d_blend_vld", i), cyc, 1024);
            wait_vld(1100, cyc);
            chk($sformatf("vec%0d_vld", i), cyc, 1024);
            check_vec(i);
        end

        // Mid-window change 100 -> 500 on the left forward pin.
        d_fl = 100; d_rl = 0; d_fr = 0; d_rr = 0;
        wait_vld(1100, cyc);
        wait_vld(1100, cyc);
        chk("blend_pre_100", int'(lft_meas), 11'h064);
        repeat (300) @(negedge clk);
        d_fl = 500;
        wait_vld(1100, cyc);
        total++;
        if (cyc < 0 || lft_meas < 11'd100 || lft_meas > 11'd500) begin
            bad++;
            $display("FAIL blend_range: got %0d expected 100..500 (vld cyc %0d)", lft_meas, cyc);
        end
        wait_vld(1100, cyc);
        chk("blend_post_500", int'(lft_meas), 11'h1F4);

        // restart asserted during the terminal cycle suppresses evaluation.
        repeat (1023) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_no_vld", int'(meas_vld), 0);
        held_errs = 0;
        cyc = -1;
        for (int i = 1; i <= 2100; i++) begin
            @(negedge clk);
            if (meas_vld) begin
                cyc = i;
                break;
            end
            if (lft_meas != 11'h1F4 || rht_meas != 11'h000) held_errs++;
        end
        chk("restart_vld_delay", cyc, 2048);
        chk("restart_hold", held_errs, 0);
        chk("restart_after_meas", int'(lft_meas), 11'h1F4);

        // Asynchronous reset mid-window clears outputs without a clock edge.
        repeat (500) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_lft_meas", int'(lft_meas), 0);
        chk("async_rst_rht_meas", int'(rht_meas), 0);
        chk("async_rst_vld", int'(meas_vld), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_vld(3000, cyc);
        chk("async_rst_warm_vld", cyc, 2048);
        chk("async_rst_meas", int'(lft_meas), 11'h1F4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
